// File: rtl/instr_encoder_loader.sv
// Packs symbolic instruction requests into 32-bit MIPS words and stores them at consecutive IMEM addresses.
// Latency: request accepted at edge N, IMEM write strobe high in cycle N+1, ready again in cycle N+2.
// Backpressure: in_ready low while a write is in flight, once capacity is reached, or after the program is closed.
module instr_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              done_in,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_FULL  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    // Number of words that fit between BASE_ADDR and the top of IMEM.
    localparam logic [ADDR_W:0]   CAP  = (ADDR_W+1)'((1 << ADDR_W) - BASE_ADDR);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   count_inc;
    logic              legal;
    logic              accept;
    logic [31:0]       enc_word;

    // Turn a mnemonic plus fields into the machine word; fields a format does not use are dropped.
    function automatic logic [31:0] encode(
        input logic [3:0]  kind,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        logic [31:0] w;
        w = 32'h0;
        case (kind)
            4'd1:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000}; // ADD
            4'd2:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010}; // SUB
            4'd3:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100100}; // AND
            4'd4:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100101}; // OR
            4'd5:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b101010}; // SLT
            4'd6:    w = {6'b100011, rs, rt, imm};                     // LW
            4'd7:    w = {6'b101011, rs, rt, imm};                     // SW
            4'd8:    w = {6'b001000, rs, rt, imm};                     // ADDI
            4'd9:    w = {6'b000100, rs, rt, imm};                     // BEQ
            4'd10:   w = {6'b000010, target};                          // J
            default: w = 32'h0;                                        // NOP and illegal kinds
        endcase
        return w;
    endfunction

    assign legal     = (in_kind <= 4'd10);
    assign in_ready  = (state == S_IDLE) & ~done_in;
    assign accept    = in_valid & in_ready;
    assign count_inc = count + 1'b1;
    assign enc_word  = encode(in_kind, in_rs, in_rt, in_rd, in_imm, in_target);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; closing the program beats a simultaneous request.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (done_in) begin
                    state_nxt = S_DONE;
                end else if (in_valid && legal) begin
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                state_nxt = (count_inc == CAP) ? S_FULL : S_IDLE;
            end
            S_FULL: begin
                if (done_in) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_DONE;
        endcase
    end

    // Registered outputs, write pointer and word counter; address and data hold between writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= BASE;
            imem_we    <= 1'b0;
            imem_addr  <= BASE;
            imem_wdata <= 32'h0;
            count      <= '0;
            full       <= 1'b0;
            err        <= 1'b0;
            done       <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (done_in) begin
                        done <= 1'b1;
                    end else if (accept && legal) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= ptr;
                        imem_wdata <= enc_word;
                    end else if (accept) begin
                        err <= 1'b1;
                    end
                end
                S_WRITE: begin
                    ptr   <= ptr + 1'b1;
                    count <= count_inc;
                    if (count_inc == CAP) begin
                        full <= 1'b1;
                    end
                end
                S_FULL: begin
                    if (done_in) begin
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
